soc_pio_ctrl: RTL
=================

Name: soc_pio_ctrl

Overview:
Parametrised Avalon-MM slave GPIO block, the next generation of the PCP benchmark/debug output PIO in the soc_system fabric. It provides:
- A WIDTH-bit output register with set/clear/toggle aliases.
- A synchronised input port with edge capture and a maskable interrupt.
- A one-shot pulse generator for timed benchmark strobes.
Readdata is registered with read latency 1 and no wait states.

Parameters:
WIDTH, 8, bits in out_port/in_port; legal 1..32.
RESET_VALUE, 0, reset value of the output register (WIDTH bits).
EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any edge.
PULSE_CYCLES, 16, pulse length in clk cycles; legal 1..65535.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address
chipselect  in  1  slave select
read  in  1  read strobe, qualified by chipselect
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data; bits above WIDTH are ignored
readdata  out  32  registered read data, zero-extended
in_port  in  WIDTH  asynchronous external inputs
out_port  out  WIDTH  output register OR active pulse bits
irq  out  1  level interrupt

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n is low:
  - out_reg = RESET_VALUE; pulse_bits, edge_cap, irq_mask = 0.
  - Pulse counter = 0; sync flops = 0; readdata = 0; irq = 0.
- Write strobe: wr = chipselect & ~write_n. Read strobe: rd = chipselect & read.
- Register map (32-bit words):
  - 0 DATA: R/W out_reg.
  - 1 INPUT: R synchronised in_port; writes ignored.
  - 2 IRQ_MASK: R/W.
  - 3 EDGE_CAP: R; write-1-to-clear per bit.
  - 4 OUTSET: W, out_reg |= wd.
  - 5 OUTCLR: W, out_reg &= ~wd.
  - 6 OUTTGL: W, out_reg ^= wd.
  - 7 PULSE: W, start pulse on bits wd; R returns {15'b0, busy, pulse_bits zero-extended to 16}.
  - Reads of 4-6 return 0.
- Read timing: readdata is updated on the clk edge where rd=1 and holds otherwise. Read latency is exactly 1.
- Input path:
  - in_port passes through a 2-flop synchroniser (s2), plus a third flop s3 for edge detection.
  - Edge event per bit: rising = s2&~s3; falling = ~s2&s3; any = s2^s3.
  - INPUT reads s2, so latency from in_port to INPUT is 2 cycles.
- Edge capture:
  - edge_cap bit sets on an edge event and stays set until cleared by a W1C write.
  - An edge event and a W1C clear on the same bit in the same cycle: set wins.
- irq = |(edge_cap & irq_mask), registered, so it asserts 1 cycle after edge_cap sets.
- Pulse generator, two states IDLE / ACTIVE:
  - IDLE, write to PULSE with wd≠0: pulse_bits = wd, cnt = PULSE_CYCLES-1, go to ACTIVE.
  - ACTIVE, cnt decrements each cycle. At cnt==0: pulse_bits = 0, go to IDLE.
  - Resulting out_port high time is exactly PULSE_CYCLES cycles.
  - ACTIVE, new PULSE write: pulse_bits |= wd and cnt reloads to PULSE_CYCLES-1 (retrigger).
  - A PULSE write with wd==0 has no effect.
- busy = (state==ACTIVE).
- out_port = out_reg | pulse_bits; combinational from registers, glitch-free.
- Only one address is written per cycle, so there are no intra-register write conflicts.
- Reset asserted mid-pulse aborts the pulse immediately; out_port shows RESET_VALUE.

Optional Feature:
Macro SOC_PIO_PULSE_EN.
- Defined: the pulse generator, counter and address 7 are present as described above.
- Undefined: no counter logic is synthesised; address 7 writes are ignored and reads return 0; out_port = out_reg.

Decomposition:
Package soc_pio_pkg holds:
- Address constants ADDR_DATA..ADDR_PULSE.
- EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
- The pulse state typedef {IDLE, ACTIVE}.
One sub-module is natural: soc_pio_pulse (counter plus FSM, WIDTH/PULSE_CYCLES params), instantiated under SOC_PIO_PULSE_EN.

Test Plan:
- Reset, then read addr 0 with RESET_VALUE=8'hA5 → readdata=32'h000000A5 one cycle after rd; out_port=8'hA5, irq=0.
- Write 0=8'h0F, 4=8'h30, 5=8'h03, 6=8'hFF → out_port after each: 0F, 3F, 3C, C3.
- EDGE_TYPE=0, mask=8'h01, in_port[0] 0→1 → edge_cap[0]=1 at cycle 3, irq=1 at cycle 4. Write 3=8'h01 → irq=0. Repeat with the clear coinciding with a new edge → edge_cap[0] remains 1.
- PULSE_CYCLES=16, write 7=8'h80 with out_reg=0 → out_port[7] high for exactly 16 cycles. Read 7 during the pulse → bit16=1.
- Mid-pulse at cycle 10, write 7=8'h01 → out_port=8'h81 for 16 cycles from the retrigger, then 0.
- Assert reset_n low at cycle 5 of a pulse → out_port=RESET_VALUE immediately, busy=0 after release.

Source files
------------

// File: rtl/soc_pio_pkg.sv
`default_nettype none
// soc_pio_pkg -- register map, edge-mode encodings and pulse FSM state for soc_pio_ctrl.
// Rev 1.0
package soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_INPUT    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_OUTTGL   = 3'd6;
  localparam logic [2:0] ADDR_PULSE    = 3'd7;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int PULSE_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

endpackage
`default_nettype wire

// File: rtl/soc_pio_pulse.sv
`default_nettype none
// soc_pio_pulse -- retriggerable one-shot: holds pulse bits high for PULSE_CYCLES clocks.
// Rev 1.0
module soc_pio_pulse
  import soc_pio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [WIDTH-1:0] pulse_bits_o,
  output logic             busy_o
);

  localparam logic [PULSE_CNT_W-1:0] c_reload = 16'(PULSE_CYCLES - 1);

  pulse_state_e           state_q, state_d;
  logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       bits_q, bits_d;
  logic                   load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
    end
  end

  // Loading with cnt = PULSE_CYCLES-1 and clearing on cnt==0 gives exactly PULSE_CYCLES high cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    load    = start_i && (wd_i != '0);
    case (state_q)
      IDLE: begin
        if (load) begin
          bits_d  = wd_i;
          cnt_d   = c_reload;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (load) begin
          bits_d = bits_q | wd_i;
          cnt_d  = c_reload;
        end else if (cnt_q == '0) begin
          bits_d  = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == ACTIVE);
    pulse_bits_o = bits_q;
  end

endmodule
`default_nettype wire

// File: rtl/soc_pio_ctrl.sv
`default_nettype none
// soc_pio_ctrl -- Avalon-MM GPIO: out reg with set/clr/tgl, edge-capture irq, optional pulse
// generator enabled by SOC_PIO_PULSE_EN. Rev 1.0
module soc_pio_ctrl
  import soc_pio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               EDGE_TYPE    = 0,
  parameter int               PULSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             wr, rd;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q, edge_ev;
  logic [WIDTH-1:0] out_reg_q, out_reg_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d, pulse_rd;
  logic             irq_q, irq_d;

  assign wr = chipselect & ~write_n;
  assign rd = chipselect & read;
  assign wd = writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_wd_unused
    logic w_unused_wd;
    assign w_unused_wd = ^writedata[31:WIDTH];
  end

  if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
    assign edge_ev = ~s2_q & s3_q;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
    assign edge_ev = s2_q ^ s3_q;
  end else begin : g_edge_rise
    assign edge_ev = s2_q & ~s3_q;
  end

`ifdef SOC_PIO_PULSE_EN
  logic [WIDTH-1:0] pulse_bits;
  logic             busy;
  logic [15:0]      pulse_lo;

  soc_pio_pulse #(
    .WIDTH        (WIDTH),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (wr && (address == ADDR_PULSE)),
    .wd_i         (wd),
    .pulse_bits_o (pulse_bits),
    .busy_o       (busy)
  );

  if (WIDTH > 16) begin : g_plo_wide
    assign pulse_lo = pulse_bits[15:0];
  end else begin : g_plo_narrow
    assign pulse_lo = 16'(pulse_bits);
  end

  assign pulse_rd = {15'b0, busy, pulse_lo};
  assign out_port = out_reg_q | pulse_bits;
`else
  assign pulse_rd = '0;
  assign out_port = out_reg_q;
`endif

  // Clear is applied before the OR so a same-cycle edge event survives a W1C.
  always_comb begin
    out_reg_d  = out_reg_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q | edge_ev;
    if (wr) begin
      case (address)
        ADDR_DATA:     out_reg_d  = wd;
        ADDR_IRQ_MASK: irq_mask_d = wd;
        ADDR_EDGE_CAP: edge_cap_d = (edge_cap_q & ~wd) | edge_ev;
        ADDR_OUTSET:   out_reg_d  = out_reg_q | wd;
        ADDR_OUTCLR:   out_reg_d  = out_reg_q & ~wd;
        ADDR_OUTTGL:   out_reg_d  = out_reg_q ^ wd;
        default:       ;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:     readdata_d = 32'(out_reg_q);
      ADDR_INPUT:    readdata_d = 32'(s2_q);
      ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
      ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
      ADDR_PULSE:    readdata_d = pulse_rd;
      default:       readdata_d = '0;
    endcase
  end

  assign irq_d = |(edge_cap_q & irq_mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      out_reg_q  <= RESET_VALUE;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      out_reg_q  <= out_reg_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
      if (rd) begin
        readdata_q <= readdata_d;
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire
